sd_cmd_sequencer: RTL and testbench



---
 rtl/sd_cmd_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_sd_cmd_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_sequencer.sv
// Queued SD command sequencer: replays each command as a register-write sequence on the
// sdc_controller byte port, polls status until completion or timeout, then reports a response.
module sd_cmd_sequencer #(
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ARG_BYTES = 2,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CMD_REG   = 5,
    parameter int unsigned FLAG_REG  = 4,
    parameter int unsigned ARG_BASE  = 2,
    parameter int unsigned TRIG_REG  = 0,
    parameter int unsigned STAT_REG  = 1,
    parameter int unsigned BUSY_BIT  = 0,
    parameter int unsigned MIN_WAIT  = 8,
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned GAP_CYC   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [5:0]                    cmd_index,
    input  logic [DATA_W-1:0]             cmd_flags,
    input  logic [ARG_BYTES*DATA_W-1:0]   cmd_arg,
    output logic                          rsp_valid,
    output logic                          rsp_err,
    output logic [5:0]                    rsp_index,
    output logic                          busy,
    output logic [ADDR_W-1:0]             reg_addr,
    output logic [DATA_W-1:0]             reg_wdata,
    output logic                          reg_we,
    input  logic [DATA_W-1:0]             reg_rdata
);

    localparam int unsigned NumWr = 3 + ARG_BYTES;
    localparam int unsigned KW    = $clog2(NumWr);
    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned TimW  = $clog2(TIMEOUT + MIN_WAIT + 2) + 1;
    localparam int unsigned GapW  = $clog2(GAP_CYC + 1) + 1;

    function automatic bit in_arg(input int unsigned r);
        return (r >= ARG_BASE) && (r < ARG_BASE + ARG_BYTES);
    endfunction

    localparam bit RegsDistinct =
        (CMD_REG != FLAG_REG) && (CMD_REG != TRIG_REG) && (CMD_REG != STAT_REG) &&
        (FLAG_REG != TRIG_REG) && (FLAG_REG != STAT_REG) && (TRIG_REG != STAT_REG) &&
        !in_arg(CMD_REG) && !in_arg(FLAG_REG) && !in_arg(TRIG_REG) && !in_arg(STAT_REG);

    if (!RegsDistinct) begin : g_bad_regs
        $error("sd_cmd_sequencer: register parameters must be pairwise distinct");
    end
    if (ARG_BYTES < 1 || ARG_BYTES > 4) begin : g_bad_arg
        $error("sd_cmd_sequencer: ARG_BYTES must be 1..4");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sd_cmd_sequencer: DEPTH must be a power of 2 and at least 2");
    end

    typedef enum logic [2:0] {StIdle, StWr, StWait, StPollA, StPollS, StRsp, StGap} state_e;
    typedef enum logic {PhSetup, PhStrobe} phase_e;

    // Command FIFO
    logic [DEPTH-1:0][5:0]                  fifo_index;
    logic [DEPTH-1:0][DATA_W-1:0]           fifo_flags;
    logic [DEPTH-1:0][ARG_BYTES*DATA_W-1:0] fifo_arg;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            push, pop;

    state_e                        state_q;
    phase_e                        phase_q;
    logic [KW-1:0]                 k_q;
    logic [TimW-1:0]               elapsed_q;
    logic [GapW-1:0]               gap_q;
    logic [5:0]                    cur_index_q;
    logic [DATA_W-1:0]             cur_flags_q;
    logic [ARG_BYTES*DATA_W-1:0]   cur_arg_q;

    assign cmd_ready = (count_q != CntW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == StIdle) && (count_q != '0);
    assign busy      = (count_q != '0) || (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_index[wr_ptr_q] <= cmd_index;
                fifo_flags[wr_ptr_q] <= cmd_flags;
                fifo_arg[wr_ptr_q]   <= cmd_arg;
                wr_ptr_q             <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Write list: CMD, FLAG, ARG_BASE+0..ARG_BYTES-1, TRIG.
    function automatic logic [ADDR_W-1:0] wr_addr(input logic [KW-1:0] k);
        int unsigned ki;
        ki = 32'(k);
        if (ki == 0)              return ADDR_W'(CMD_REG);
        else if (ki == 1)         return ADDR_W'(FLAG_REG);
        else if (ki < NumWr - 1)  return ADDR_W'(ARG_BASE + ki - 2);
        else                      return ADDR_W'(TRIG_REG);
    endfunction

    function automatic logic [DATA_W-1:0] wr_data(input logic [KW-1:0] k,
                                                  input logic [5:0] idx,
                                                  input logic [DATA_W-1:0] flags,
                                                  input logic [ARG_BYTES*DATA_W-1:0] arg);
        int unsigned ki;
        ki = 32'(k);
        if (ki == 0)              return DATA_W'(idx);
        else if (ki == 1)         return flags;
        else if (ki < NumWr - 1)  return arg[(ki - 2) * DATA_W +: DATA_W];
        else                      return '0;
    endfunction

    logic unused_rdata;
    assign unused_rdata = ^reg_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            phase_q     <= PhSetup;
            k_q         <= '0;
            elapsed_q   <= '0;
            gap_q       <= '0;
            cur_index_q <= '0;
            cur_flags_q <= '0;
            cur_arg_q   <= '0;
            reg_addr    <= '0;
            reg_wdata   <= '0;
            reg_we      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_index   <= '0;
        end else begin
            reg_we    <= 1'b0;
            rsp_valid <= 1'b0;
            // Elapsed time since the trigger strobe, saturating, frozen from RSP onwards.
            if ((state_q == StWait || state_q == StPollA || state_q == StPollS) &&
                elapsed_q != '1) begin
                elapsed_q <= elapsed_q + 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (count_q != '0) begin
                        cur_index_q <= fifo_index[rd_ptr_q];
                        cur_flags_q <= fifo_flags[rd_ptr_q];
                        cur_arg_q   <= fifo_arg[rd_ptr_q];
                        k_q         <= '0;
                        phase_q     <= PhSetup;
                        reg_addr    <= wr_addr('0);
                        reg_wdata   <= wr_data('0, fifo_index[rd_ptr_q], fifo_flags[rd_ptr_q],
                                               fifo_arg[rd_ptr_q]);
                        state_q     <= StWr;
                    end
                end
                StWr: begin
                    if (phase_q == PhSetup) begin
                        reg_we  <= 1'b1;
                        phase_q <= PhStrobe;
                    end else begin
                        phase_q <= PhSetup;
                        if (k_q == KW'(NumWr - 1)) begin
                            elapsed_q <= TimW'(1);
                            if (MIN_WAIT == 0) begin
                                reg_addr <= ADDR_W'(STAT_REG);
                                state_q  <= StPollA;
                            end else begin
                                state_q  <= StWait;
                            end
                        end else begin
                            k_q       <= k_q + 1'b1;
                            reg_addr  <= wr_addr(k_q + 1'b1);
                            reg_wdata <= wr_data(k_q + 1'b1, cur_index_q, cur_flags_q, cur_arg_q);
                        end
                    end
                end
                StWait: begin
                    if (elapsed_q >= TimW'(MIN_WAIT)) begin
                        reg_addr <= ADDR_W'(STAT_REG);
                        state_q  <= StPollA;
                    end
                end
                StPollA: begin
                    state_q <= StPollS;
                end
                StPollS: begin
                    // Checking busy first lets a completion seen at the timeout sample win.
                    if (!reg_rdata[BUSY_BIT]) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_index <= cur_index_q;
                        state_q   <= StRsp;
                    end else if (elapsed_q >= TimW'(TIMEOUT)) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_index <= cur_index_q;
                        state_q   <= StRsp;
                    end else begin
                        state_q   <= StPollA;
                    end
                end
                StRsp: begin
                    gap_q <= '0;
                    if (GAP_CYC == 0) begin
                        state_q <= StIdle;
                    end else begin
                        state_q <= StGap;
                    end
                end
                StGap: begin
                    if (gap_q == GapW'(GAP_CYC - 1)) begin
                        state_q <= StIdle;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Scoreboard bench for sd_cmd_sequencer: stimulus queues expected writes/responses,
// a negedge monitor compares them, and a small controller model answers status polls.
module tb_sd_cmd_sequencer;

    localparam int GAP = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_index = '0;
    logic [7:0]  cmd_flags = '0;
    logic [15:0] cmd_arg = '0;
    logic        rsp_valid, rsp_err, busy, reg_we;
    logic [5:0]  rsp_index;
    logic [6:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata = '0;

    sd_cmd_sequencer #(.TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index),
        .cmd_flags(cmd_flags), .cmd_arg(cmd_arg),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_index(rsp_index), .busy(busy),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_rdata(reg_rdata)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Controller model: trigger sets busy; clears 20 cycles later unless stuck.
    bit st_stuck = 1'b0;
    logic st_busy = 1'b0;
    int st_cnt = 0;
    always @(posedge clk) begin
        reg_rdata <= (reg_addr == 7'd1) ? {7'h7F, st_busy} : 8'h00;
        if (reg_we && reg_addr == 7'd0) begin
            st_busy <= 1'b1;
            st_cnt  <= st_stuck ? 0 : 20;
        end else if (st_cnt == 1) begin
            st_busy <= 1'b0;
            st_cnt  <= 0;
        end else if (st_cnt != 0) begin
            st_cnt <= st_cnt - 1;
        end
    end

    typedef struct { logic [6:0] addr; logic [7:0] data; bit chk_gap; int first_at; } wr_t;
    typedef struct { bit err; logic [5:0] idx; int lo; int hi; } rsp_t;
    wr_t wq[$];
    rsp_t rq[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor
    wr_t  mw;
    rsp_t mr;
    logic       prev_we = 1'b0;
    logic [6:0] prev_addr = '0;
    logic [7:0] prev_data = '0;
    int trig_cycle = 0;
    int last_rsp = 0;
    int rsp_seen = 0;
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (reg_we === 1'b1) begin
                if (wq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected none",
                             reg_addr, reg_wdata);
                end else begin
                    mw = wq.pop_front();
                    check("wr_addr", 32'(reg_addr), 32'(mw.addr));
                    check("wr_data", 32'(reg_wdata), 32'(mw.data));
                    check("wr_setup", {16'h0, prev_we, prev_addr, prev_data},
                          {16'h0, 1'b0, reg_addr, reg_wdata});
                    if (mw.chk_gap) check("gap_to_strobe", cycle - last_rsp, GAP + 3);
                    if (mw.first_at >= 0) check("first_strobe_cycle", cycle, mw.first_at);
                end
                if (reg_addr == 7'd0) trig_cycle = cycle;
            end
            if (rsp_valid === 1'b1) begin
                rsp_seen++;
                if (rq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rsp: got index %0d err %0b, expected none",
                             rsp_index, rsp_err);
                end else begin
                    mr = rq.pop_front();
                    check("rsp_err", 32'(rsp_err), 32'(mr.err));
                    check("rsp_index", 32'(rsp_index), 32'(mr.idx));
                    check("rsp_latency_in_window",
                          32'((cycle - trig_cycle >= mr.lo) && (cycle - trig_cycle <= mr.hi)),
                          32'd1);
                end
                last_rsp = cycle;
            end
        end
        prev_we   = reg_we;
        prev_addr = reg_addr;
        prev_data = reg_wdata;
    end

    // Offer one command for one cycle; called #1 after a posedge.
    task automatic offer(input logic [5:0] idx, input logic [7:0] fl, input logic [15:0] arg,
                         input bit chk_first, input bit chk_gap, output bit acc);
        cmd_valid = 1'b1;
        cmd_index = idx;
        cmd_flags = fl;
        cmd_arg   = arg;
        acc = cmd_ready;
        if (acc) begin
            wq.push_back('{addr: 7'd5, data: {2'b00, idx}, chk_gap: chk_gap,
                           first_at: chk_first ? cycle + 3 : -1});
            wq.push_back('{addr: 7'd4, data: fl, chk_gap: 1'b0, first_at: -1});
            wq.push_back('{addr: 7'd2, data: arg[7:0], chk_gap: 1'b0, first_at: -1});
            wq.push_back('{addr: 7'd3, data: arg[15:8], chk_gap: 1'b0, first_at: -1});
            wq.push_back('{addr: 7'd0, data: 8'h00, chk_gap: 1'b0, first_at: -1});
            if (st_stuck) rq.push_back('{err: 1'b1, idx: idx, lo: 64, hi: 66});
            else          rq.push_back('{err: 1'b0, idx: idx, lo: 23, hi: 23});
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (!busy && wq.size() == 0 && rq.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drained_idle", {29'h0, busy, wq.size() != 0, rq.size() != 0}, 32'h0);
    endtask

    bit acc;
    int n_acc;
    int seen_before;
    bit found;

    initial begin
        // Reset held 3 cycles
        repeat (3) @(posedge clk);
        #1;
        check("rst_reg_addr", 32'(reg_addr), 32'h0);
        check("rst_reg_wdata", 32'(reg_wdata), 32'h0);
        check("rst_reg_we", 32'(reg_we), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'h0);
        check("rst_rsp_index", 32'(rsp_index), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // CMD0
        offer(6'd0, 8'h00, 16'h0000, 1'b1, 1'b0, acc);
        check("cmd0_accepted", 32'(acc), 32'h1);
        wait_idle(300);

        // CMD7 then CMD17 back-to-back
        offer(6'd7, 8'h00, 16'h0013, 1'b1, 1'b0, acc);
        offer(6'd17, 8'h3D, 16'h0200, 1'b0, 1'b1, acc);
        wait_idle(400);

        // Status stuck busy: six continuous offers, DEPTH+1 accepted, all time out
        st_stuck = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            offer(6'(20 + i), 8'(i), 16'hA000 + 16'(i), 1'b0, n_acc != 0, acc);
            if (acc) n_acc++;
        end
        check("accepted_count", n_acc, 5);
        check("ready_low_when_full", 32'(cmd_ready), 32'h0);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (rsp_valid) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("first_rsp_seen", 32'(found), 32'h1);
        check("ready_low_at_first_rsp", 32'(cmd_ready), 32'h0);
        wait_idle(1000);

        // Next command after timeouts completes normally
        st_stuck = 1'b0;
        offer(6'd9, 8'h5A, 16'hBEEF, 1'b1, 1'b0, acc);
        wait_idle(300);

        // Reset during argument write of a queued pair
        st_stuck = 1'b1;
        offer(6'd3, 8'h11, 16'h2233, 1'b0, 1'b0, acc);
        offer(6'd4, 8'h44, 16'h5566, 1'b0, 1'b0, acc);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (reg_we && reg_addr == 7'd2) begin
                found = 1'b1;
                break;
            end
        end
        check("arg_write_seen", 32'(found), 32'h1);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        wq.delete();
        rq.delete();
        seen_before = rsp_seen;
        check("midrst_reg_we", 32'(reg_we), 32'h0);
        check("midrst_reg_addr", 32'(reg_addr), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'h1);
        rst = 1'b0;
        repeat (150) @(posedge clk);
        #1;
        check("no_rsp_after_rst", rsp_seen, seen_before);
        check("idle_after_rst_busy", 32'(busy), 32'h0);
        check("idle_after_rst_ready", 32'(cmd_ready), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
